// File: rtl/encoder_16x4_arb.sv
// Sequential 16-to-4 priority encoder with sticky request capture and a
// valid/acknowledge handshake; the code is held until the consumer acks it.
module encoder_16x4_arb #(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] D,
  input  logic        ACK,
  output logic        W,
  output logic        X,
  output logic        Y,
  output logic        Z,
  output logic        V,
  output logic [15:0] PEND
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t      state_q, state_d;
  logic [15:0] pend_q, pend_d;
  logic [3:0]  code_q, code_d;
  logic [15:0] clr_mask;
  logic [3:0]  win;

  // Candidates are the next pending value, so a same-cycle request or a
  // re-request of the acked line is visible to the winner pick.
  always_comb begin
    clr_mask = '0;
    if (state_q == HOLD && ACK)
      clr_mask = 16'h0001 << code_q;
    pend_d = (pend_q & ~clr_mask) | D;
  end

  always_comb begin
    win = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (PRIORITY_HIGH) begin
        if (pend_d[i]) win = 4'(i);
      end else begin
        if (pend_d[15 - i]) win = 4'(15 - i);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      IDLE: begin
        if (pend_d != '0) begin
          code_d  = win;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (ACK) begin
          if (pend_d != '0) code_d = win;
          else              state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      code_q  <= code_d;
    end
  end

  assign {W, X, Y, Z} = code_q;
  assign V            = (state_q == HOLD);
  assign PEND         = pend_q;

endmodule

// File: tb/tb_encoder_16x4_arb.sv
// Directed bench for encoder_16x4_arb: one instance per priority order.
module tb_encoder_16x4_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d_h, d_l;
  logic        ack_h, ack_l;
  logic        w_h, x_h, y_h, z_h, v_h;
  logic        w_l, x_l, y_l, z_l, v_l;
  logic [15:0] pend_h, pend_l;
  logic [3:0]  code_h, code_l;

  int n_checks = 0;
  int n_fail   = 0;

  assign code_h = {w_h, x_h, y_h, z_h};
  assign code_l = {w_l, x_l, y_l, z_l};

  always #5 clk = ~clk;

  encoder_16x4_arb #(.PRIORITY_HIGH(1'b1)) dut_h (
    .clk(clk), .rst_n(rst_n), .D(d_h), .ACK(ack_h),
    .W(w_h), .X(x_h), .Y(y_h), .Z(z_h), .V(v_h), .PEND(pend_h)
  );

  encoder_16x4_arb #(.PRIORITY_HIGH(1'b0)) dut_l (
    .clk(clk), .rst_n(rst_n), .D(d_l), .ACK(ack_l),
    .W(w_l), .X(x_l), .Y(y_l), .Z(z_l), .V(v_l), .PEND(pend_l)
  );

  task automatic test_reset();
    rst_n = 1'b0; d_h = '0; d_l = '0; ack_h = 1'b0; ack_l = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({v_h, code_h, pend_h} !== 21'h0) begin
      n_fail++; $display("FAIL reset_h: V=%b code=%b PEND=%h, want 0/0000/0000", v_h, code_h, pend_h);
    end
    n_checks++;
    if ({v_l, code_l, pend_l} !== 21'h0) begin
      n_fail++; $display("FAIL reset_l: V=%b code=%b PEND=%h, want 0/0000/0000", v_l, code_l, pend_l);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    d_h = 16'h0020;
    @(negedge clk); d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0101 || pend_h !== 16'h0020) begin
      n_fail++; $display("FAIL single_present: V=%b code=%b PEND=%h, want 1/0101/0020", v_h, code_h, pend_h);
    end
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b0 || pend_h !== 16'h0000 || code_h !== 4'b0101) begin
      n_fail++; $display("FAIL single_ack: V=%b code=%b PEND=%h, want 0/0101/0000", v_h, code_h, pend_h);
    end
  endtask

  task automatic test_priority();
    d_h = 16'h8001;
    @(negedge clk); d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b1111 || pend_h !== 16'h8001) begin
      n_fail++; $display("FAIL prio_first: V=%b code=%b PEND=%h, want 1/1111/8001", v_h, code_h, pend_h);
    end
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0000 || pend_h !== 16'h0001) begin
      n_fail++; $display("FAIL prio_second: V=%b code=%b PEND=%h, want 1/0000/0001", v_h, code_h, pend_h);
    end
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b0 || pend_h !== 16'h0000 || code_h !== 4'b0000) begin
      n_fail++; $display("FAIL prio_drain: V=%b code=%b PEND=%h, want 0/0000/0000", v_h, code_h, pend_h);
    end
    // ACK with V=0 must be ignored
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b0 || pend_h !== 16'h0000 || code_h !== 4'b0000) begin
      n_fail++; $display("FAIL idle_ack: V=%b code=%b PEND=%h, want 0/0000/0000", v_h, code_h, pend_h);
    end
  endtask

  task automatic test_no_preempt();
    d_h = 16'h0008;
    @(negedge clk); d_h = 16'h4000;
    @(negedge clk); d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0011 || pend_h !== 16'h4008) begin
      n_fail++; $display("FAIL nopreempt_hold: V=%b code=%b PEND=%h, want 1/0011/4008", v_h, code_h, pend_h);
    end
    @(negedge clk);
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0011) begin
      n_fail++; $display("FAIL nopreempt_stable: V=%b code=%b, want 1/0011", v_h, code_h);
    end
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b1110 || pend_h !== 16'h4000) begin
      n_fail++; $display("FAIL nopreempt_next: V=%b code=%b PEND=%h, want 1/1110/4000", v_h, code_h, pend_h);
    end
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b0 || pend_h !== 16'h0000) begin
      n_fail++; $display("FAIL nopreempt_drain: V=%b PEND=%h, want 0/0000", v_h, pend_h);
    end
  endtask

  task automatic test_set_wins();
    d_h = 16'h0080;
    @(negedge clk); d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0111) begin
      n_fail++; $display("FAIL setwins_present: V=%b code=%b, want 1/0111", v_h, code_h);
    end
    ack_h = 1'b1; d_h = 16'h0080;
    @(negedge clk); ack_h = 1'b0; d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0111 || pend_h !== 16'h0080) begin
      n_fail++; $display("FAIL setwins_keep: V=%b code=%b PEND=%h, want 1/0111/0080", v_h, code_h, pend_h);
    end
    ack_h = 1'b1;
    @(negedge clk); ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b0 || pend_h !== 16'h0000) begin
      n_fail++; $display("FAIL setwins_drain: V=%b PEND=%h, want 0/0000", v_h, pend_h);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_pend;
    d_l = 16'hFFFF; ack_l = 1'b1;
    @(negedge clk); d_l = '0;
    for (int i = 0; i < 16; i++) begin
      exp_pend = 16'hFFFF << i;
      n_checks++;
      if (v_l !== 1'b1 || code_l !== 4'(i) || pend_l !== exp_pend) begin
        n_fail++; $display("FAIL b2b_step%0d: V=%b code=%b PEND=%h, want 1/%b/%h", i, v_l, code_l, pend_l, 4'(i), exp_pend);
      end
      @(negedge clk);
    end
    ack_l = 1'b0;
    n_checks++;
    if (v_l !== 1'b0 || pend_l !== 16'h0000 || code_l !== 4'b1111) begin
      n_fail++; $display("FAIL b2b_drain: V=%b code=%b PEND=%h, want 0/1111/0000", v_l, code_l, pend_l);
    end
  endtask

  task automatic test_async_reset();
    d_h = 16'h0F00;
    @(negedge clk); d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b1011 || pend_h !== 16'h0F00) begin
      n_fail++; $display("FAIL areset_pre: V=%b code=%b PEND=%h, want 1/1011/0F00", v_h, code_h, pend_h);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (v_h !== 1'b0 || code_h !== 4'b0000 || pend_h !== 16'h0000) begin
      n_fail++; $display("FAIL areset_now: V=%b code=%b PEND=%h, want 0/0000/0000", v_h, code_h, pend_h);
    end
    @(negedge clk); rst_n = 1'b1;
    ack_h = 1'b1;
    repeat (2) @(negedge clk);
    ack_h = 1'b0;
    n_checks++;
    if (v_h !== 1'b0 || code_h !== 4'b0000 || pend_h !== 16'h0000) begin
      n_fail++; $display("FAIL areset_ack: V=%b code=%b PEND=%h, want 0/0000/0000", v_h, code_h, pend_h);
    end
    d_h = 16'h0004;
    @(negedge clk); d_h = '0;
    n_checks++;
    if (v_h !== 1'b1 || code_h !== 4'b0010 || pend_h !== 16'h0004) begin
      n_fail++; $display("FAIL areset_first: V=%b code=%b PEND=%h, want 1/0010/0004", v_h, code_h, pend_h);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_no_preempt();
    test_set_wins();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
